// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies num words from src to dest in a single-port RAM,
// one word per RD/LAT/WR triple, ascending addresses.
module mem_copy_engine #(
   parameter int DATA_WITH = 8,
   parameter int ADDR_WITH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_WITH-1:0] src,
   input  logic [ADDR_WITH-1:0] dest,
   input  logic [ADDR_WITH-1:0] num,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [ADDR_WITH-1:0] ram_addr,
   output logic [DATA_WITH-1:0] ram_wdata,
   output logic                 ram_we,
   output logic                 ram_oe,
   input  logic [DATA_WITH-1:0] ram_rdata
);

   // Depth as an (ADDR_WITH+1)-bit value so range sums compare without truncation.
   localparam logic [ADDR_WITH:0]   DEPTH_V = {1'b1, {ADDR_WITH{1'b0}}};
   localparam logic [ADDR_WITH-1:0] A_ONE   = ADDR_WITH'(1);
   localparam logic [ADDR_WITH-1:0] A_ZERO  = '0;

   typedef enum logic [2:0] {IDLE, RD, LAT, WR, FIN} state_t;

   state_t               state, state_nxt;
   logic [ADDR_WITH-1:0] src_r, dest_r, num_r, idx;
   logic [DATA_WITH-1:0] data_r;
   logic                 reject;
   logic [ADDR_WITH:0]   src_end, dest_end;
   logic                 range_bad;

   // A request is out of range when either window runs past the top of RAM.
   assign src_end   = {1'b0, src}  + {1'b0, num};
   assign dest_end  = {1'b0, dest} + {1'b0, num};
   assign range_bad = (src_end > DEPTH_V) || (dest_end > DEPTH_V);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Request capture, word index and read-data holding register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src_r  <= '0;
         dest_r <= '0;
         num_r  <= '0;
         idx    <= '0;
         data_r <= '0;
         reject <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               src_r  <= src;
               dest_r <= dest;
               num_r  <= num;
               idx    <= '0;
               reject <= range_bad;
            end
            LAT:     data_r <= ram_rdata;
            WR:      idx    <= idx + A_ONE;
            default: ;
         endcase
      end
   end

   // Next state plus outputs; outputs depend on registered state/data only.
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      ram_oe    = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            // Zero-length and out-of-range requests both go straight to FIN.
            if (start) state_nxt = (num == A_ZERO || range_bad) ? FIN : RD;
         end
         RD: begin
            ram_addr  = src_r + idx;
            ram_oe    = 1'b1;
            state_nxt = LAT;
         end
         LAT: state_nxt = WR;
         WR: begin
            ram_addr  = dest_r + idx;
            ram_wdata = data_r;
            ram_we    = 1'b1;
            state_nxt = (idx == num_r - A_ONE) ? FIN : RD;
         end
         FIN: begin
            done      = 1'b1;
            error     = reject;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Protocol invariants.
   a_we_oe: assert property (@(posedge clk) disable iff (!rst_n) !(ram_we && ram_oe));
   a_done:  assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
   a_busy:  assert property (@(posedge clk) disable iff (!rst_n) (state == IDLE) |-> !busy);

endmodule
